// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one operand bit per clock)
// with a start/busy/done handshake and an overflow flag for results that do not
// fit in NDIGITS digits.
// Optional feature: define SIGNED_MODE_EN to treat bin_in as two's complement;
// the magnitude is converted and the operand sign is reported on sign_out.
module bin2bcd_seq #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned NDIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DWIDTH-1:0]      bin_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   bcd_out,
  output logic                   overflow,
  output logic                   sign_out
);

  localparam int unsigned BW = 4 * NDIGITS;
  localparam int unsigned CW = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_shift;
  logic [BW-1:0]     r_acc;
  logic              r_ovf;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [BW-1:0]     r_bcd;
  logic              r_ovf_out;

  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_acc_next;
  logic              w_carry;
  logic [DWIDTH-1:0] w_mag;
  logic              w_accept;
  logic              w_last;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(1));

`ifdef SIGNED_MODE_EN
  // Magnitude of a two's complement operand; the most negative value maps to
  // 2^(DWIDTH-1), which still fits in DWIDTH unsigned bits.
  assign w_mag = bin_in[DWIDTH-1] ? (~bin_in + DWIDTH'(1)) : bin_in;
`else
  assign w_mag = bin_in;
`endif

  // Add 3 to every digit that is 5 or more; digits are independent (no carry).
  always_comb begin
    w_adj = r_acc;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift the next operand bit into the digit chain; the top bit falls out.
  assign w_acc_next = {w_adj[BW-2:0], r_shift[DWIDTH-1]};
  assign w_carry    = w_adj[BW-1];

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shift <= w_mag;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CW'(DWIDTH);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_shift <= {r_shift[DWIDTH-2:0], 1'b0};
          r_acc   <= w_acc_next;
          r_ovf   <= r_ovf | w_carry;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd     <= w_acc_next;
            r_ovf_out <= r_ovf | w_carry;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf_out;

`ifdef SIGNED_MODE_EN
  logic r_sign_pend;
  logic r_sign_out;

  // Capture operand sign on accept; publish it together with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_pend <= 1'b0;
      r_sign_out  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign_pend <= bin_in[DWIDTH-1];
      end
      if (w_last) begin
        r_sign_out <= r_sign_pend;
      end
    end
  end

  assign sign_out = r_sign_out;
`else
  assign sign_out = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit instance share
// clock, reset and stimulus; results are compared with an arithmetic model.
module tb_bin2bcd_seq;

  localparam int unsigned DW = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy, done, overflow, sign_out;
  logic [11:0] bcd_out;
  logic        busy2, done2, overflow2, sign_out2;
  logic [7:0]  bcd_out2;

  int n_cmp;
  int n_err;

  bin2bcd_seq #(.DWIDTH(DW), .NDIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out),
    .overflow(overflow), .sign_out(sign_out)
  );

  bin2bcd_seq #(.DWIDTH(DW), .NDIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2),
    .overflow(overflow2), .sign_out(sign_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand value.
  function automatic void ref_conv(input logic [7:0] b, input int nd,
                                   output logic [11:0] bcd, output logic ovf,
                                   output logic sg);
    int v, lim, t;
`ifdef SIGNED_MODE_EN
    sg = b[7];
    v  = sg ? 256 - int'(b) : int'(b);
`else
    sg = 1'b0;
    v  = int'(b);
`endif
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ovf = (v >= lim);
    t   = v % lim;
    bcd = '0;
    for (int i = 0; i < nd; i++) begin
      bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  // One conversion; called at a negedge, returns at the negedge after done.
  task automatic convert(input logic [7:0] b,
                         output logic [11:0] r3, output logic o3,
                         output logic [7:0] r2, output logic o2,
                         output logic s, output int lat, output int nbusy);
    start  = 1'b1;
    bin_in = b;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'($urandom);
    lat    = 0;
    nbusy  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    r3 = bcd_out;
    o3 = overflow;
    r2 = bcd_out2;
    o2 = overflow2;
    s  = sign_out;
    chk("done2_sync", 32'(done2), 32'(done));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
  endtask

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        sg;
  } vec_t;

  vec_t tbl [6];

  initial begin : main
    logic [11:0] r3, e3, ra, rb;
    logic [7:0]  r2;
    logic        o3, o2, s, eo3, eo2, es, es2;
    logic [11:0] e2w;
    logic [7:0]  rv;
    int          lat, nbusy, d1, d2, nd, both;

    n_cmp = 0;
    n_err = 0;

`ifdef SIGNED_MODE_EN
    tbl[0] = '{8'h80, 12'h128, 1'b0, 8'h28, 1'b1, 1'b1};
    tbl[1] = '{8'hFF, 12'h001, 1'b0, 8'h01, 1'b0, 1'b1};
    tbl[2] = '{8'h7F, 12'h127, 1'b0, 8'h27, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'd99, 12'h099, 1'b0, 8'h99, 1'b0, 1'b0};
    tbl[5] = '{8'd200, 12'h056, 1'b0, 8'h56, 1'b0, 1'b1};
`else
    tbl[0] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[1] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0};
    tbl[3] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'd200, 12'h200, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0, 1'b0};
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_sign", 32'(sign_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      convert(tbl[i].bin, r3, o3, r2, o2, s, lat, nbusy);
      chk("tbl_bcd3", 32'(r3), 32'(tbl[i].bcd3));
      chk("tbl_ovf3", 32'(o3), 32'(tbl[i].ovf3));
      chk("tbl_bcd2", 32'(r2), 32'(tbl[i].bcd2));
      chk("tbl_ovf2", 32'(o2), 32'(tbl[i].ovf2));
      chk("tbl_sign", 32'(s),  32'(tbl[i].sg));
      chk("tbl_latency", 32'(lat), 32'(DW + 1));
      chk("tbl_busy_cycles", 32'(nbusy), 32'(DW));
    end

    // Back-to-back with start held high; bin_in changes during SHIFT ignored
    start  = 1'b1;
    bin_in = 8'd37;
    @(posedge clk);
    d1 = 0; d2 = 0; both = 0;
    ra = '0; rb = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) bin_in = 8'd200;
      if (busy && done) both++;
      if (done) begin
        if (d1 == 0) begin
          d1 = k;
          ra = bcd_out;
        end else if (d2 == 0) begin
          d2 = k;
          rb = bcd_out;
        end
      end
      if (d1 != 0 && k == d1 + 1) start = 1'b0;
    end
    ref_conv(8'd37, 3, e3, eo3, es);
    chk("b2b_first_at", 32'(d1), 32'(DW + 1));
    chk("b2b_first_bcd", 32'(ra), 32'(e3));
    ref_conv(8'd200, 3, e3, eo3, es);
    chk("b2b_spacing", 32'(d2 - d1), 32'(DW + 1));
    chk("b2b_second_bcd", 32'(rb), 32'(e3));
    chk("b2b_sign", 32'(sign_out), 32'(es));
    chk("busy_and_done", 32'(both), 0);

    // Start pulse while busy must not add a conversion
    start  = 1'b1;
    bin_in = 8'd99;
    @(posedge clk);
    nd = 0; rv = '0;
    e2w = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin
        start  = 1'b1;
        bin_in = 8'd5;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        nd++;
        e2w = bcd_out;
      end
    end
    ref_conv(8'd99, 3, e3, eo3, es);
    chk("busy_start_dones", 32'(nd), 1);
    chk("busy_start_bcd", 32'(e2w), 32'(e3));

    // Reset in the middle of a conversion of 255
    start  = 1'b1;
    bin_in = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_bcd", 32'(bcd_out), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_sign", 32'(sign_out), 0);
    chk("midrst_bcd2", 32'(bcd_out2), 0);
    nd = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done || done2) nd++;
    end
    chk("midrst_no_done", 32'(nd), 0);
    convert(8'd42, r3, o3, r2, o2, s, lat, nbusy);
    chk("post_rst_bcd", 32'(r3), 32'h042);
    chk("post_rst_latency", 32'(lat), 32'(DW + 1));

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      convert(rv, r3, o3, r2, o2, s, lat, nbusy);
      ref_conv(rv, 3, e3, eo3, es);
      ref_conv(rv, 2, e2w, eo2, es2);
      chk("rnd_bcd3", 32'(r3), 32'(e3));
      chk("rnd_ovf3", 32'(o3), 32'(eo3));
      chk("rnd_bcd2", 32'(r2), 32'(e2w[7:0]));
      chk("rnd_ovf2", 32'(o2), 32'(eo2));
      chk("rnd_sign", 32'(s), 32'(es));
      chk("rnd_latency", 32'(lat), 32'(DW + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
